// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared constants and types for the programmable clock divider
//   Contents: DIV_RST (ratio after reset), DIV_MIN (clamp floor for loaded ratios),
//   TICK_CNT_W (width of the optional tick counter), div_t (default-width ratio type).
//   Optional feature macro used by the bundle: CLKDIV_TICK_CNT_EN.
package clkdiv_pkg;

  localparam int DIV_RST    = 8;
  localparam int DIV_MIN    = 2;
  localparam int TICK_CNT_W = 16;
  localparam int CNT_W_DEF  = 8;

  typedef logic [CNT_W_DEF-1:0] div_t;

endpackage

// File: rtl/clkdiv_prog_if.sv
// rtl/clkdiv_prog_if.sv - control/status bundle of the programmable clock divider
//   Signals: en, div_in[CNT_W], div_ld (driven by master)
//            div_busy, clk_out, tick, tick_cnt[16] when CLKDIV_TICK_CNT_EN (driven by slave)
//   Modports: master = controller/consumer side, slave = clkdiv_prog.
interface clkdiv_prog_if #(
  parameter int CNT_W = 8
);
  import clkdiv_pkg::*;

  logic             en;
  logic [CNT_W-1:0] div_in;
  logic             div_ld;
  logic             div_busy;
  logic             clk_out;
  logic             tick;
`ifdef CLKDIV_TICK_CNT_EN
  logic [TICK_CNT_W-1:0] tick_cnt;

  modport master (
    output en, div_in, div_ld,
    input  div_busy, clk_out, tick, tick_cnt
  );

  modport slave (
    input  en, div_in, div_ld,
    output div_busy, clk_out, tick, tick_cnt
  );
`else
  modport master (
    output en, div_in, div_ld,
    input  div_busy, clk_out, tick
  );

  modport slave (
    input  en, div_in, div_ld,
    output div_busy, clk_out, tick
  );
`endif

endinterface

// File: rtl/clkdiv_ratio_reg.sv
// rtl/clkdiv_ratio_reg.sv - pending/active divide ratio registers with clamp and busy flag
//   Ports: clk, rst_ (sync, active-low)
//          div_ld, div_in[CNT_W] : load strobe and requested ratio
//          apply                 : period start or idle; promotes the pending ratio
//          ratio[CNT_W]          : active ratio used by the phase counter
//          div_busy              : a pending ratio is waiting to become active
module clkdiv_ratio_reg
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             div_ld,
  input  logic [CNT_W-1:0] div_in,
  input  logic             apply,
  output logic [CNT_W-1:0] ratio,
  output logic             div_busy
);

  localparam logic [CNT_W-1:0] RST_V = CNT_W'(DIV_RST);
  localparam logic [CNT_W-1:0] MIN_V = CNT_W'(DIV_MIN);

  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic             busy_q, busy_d;

  always_comb begin
    pend_d = pend_q;
    act_d  = act_q;
    busy_d = busy_q;
    // Promotion uses the value pending before this edge, so a load on the
    // same edge is held back until the following apply.
    if (apply && busy_q) begin
      act_d  = pend_q;
      busy_d = 1'b0;
    end
    if (div_ld) begin
      pend_d = (div_in < MIN_V) ? MIN_V : div_in;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      pend_q <= RST_V;
      act_q  <= RST_V;
      busy_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      act_q  <= act_d;
      busy_q <= busy_d;
    end
  end

  assign ratio    = act_q;
  assign div_busy = busy_q;

endmodule

// File: rtl/clkdiv_prog.sv
// rtl/clkdiv_prog.sv - programmable glitch-free synchronous clock divider with tick output
//   Ports: clk          : single clock, rising edge
//          rst_         : synchronous active-low reset
//          bus (slave)  : en, div_in, div_ld in; div_busy, clk_out, tick out;
//                         tick_cnt out when CLKDIV_TICK_CNT_EN is defined
//   Period is N clk cycles: floor(N/2) high, remainder low; tick marks each rising clk_out.
module clkdiv_prog
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst_,
  clkdiv_prog_if.slave bus
);

  logic [CNT_W-1:0] ratio;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             run_q, run_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             start;
  logic             apply;
  logic             div_busy;

  // Ratio changes land only on period boundaries (or while idle), which is
  // what keeps clk_out free of runt pulses.
  clkdiv_ratio_reg #(
    .CNT_W(CNT_W)
  ) u_ratio (
    .clk     (clk),
    .rst_    (rst_),
    .div_ld  (bus.div_ld),
    .div_in  (bus.div_in),
    .apply   (apply),
    .ratio   (ratio),
    .div_busy(div_busy)
  );

  assign half    = ratio >> 1;
  assign cnt_inc = cnt_q + CNT_W'(1);

  // cnt_q is the position inside the running period (0 = tick cycle).
  always_comb begin
    run_d     = run_q;
    cnt_d     = cnt_q;
    clk_out_d = 1'b0;
    tick_d    = 1'b0;
    start     = 1'b0;
    if (!bus.en) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (!run_q || (cnt_q == ratio - CNT_W'(1))) begin
      start     = 1'b1;
      run_d     = 1'b1;
      cnt_d     = '0;
      clk_out_d = 1'b1;
      tick_d    = 1'b1;
    end else begin
      cnt_d     = cnt_inc;
      clk_out_d = (cnt_inc < half);
    end
  end

  assign apply = start || !run_q;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      run_q     <= 1'b0;
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      run_q     <= run_d;
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

`ifdef CLKDIV_TICK_CNT_EN
  logic [TICK_CNT_W-1:0] tick_cnt_q, tick_cnt_d;

  // Free-running count of issued ticks; only reset clears it.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (tick_d) begin
      tick_cnt_d = tick_cnt_q + TICK_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign bus.tick_cnt = tick_cnt_q;
`endif

  assign bus.clk_out  = clk_out_q;
  assign bus.tick     = tick_q;
  assign bus.div_busy = div_busy;

endmodule

// File: tb/tb_clkdiv_prog.sv
// tb/tb_clkdiv_prog.sv - self-checking bench for clkdiv_prog against a period-position model
module tb_clkdiv_prog;
  import clkdiv_pkg::*;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_ = 1'b0;

  always #5 clk = ~clk;

  clkdiv_prog_if #(.CNT_W(CNT_W)) bus ();

  clkdiv_prog #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst_(rst_),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: where we are inside the current period and which ratio it uses.
  bit m_run;
  int m_pos;
  int m_n;
  int m_pend;
  bit m_busy;
  int m_tcnt;

  function automatic bit e_clk();
    return m_run && (m_pos < m_n / 2);
  endfunction

  function automatic bit e_tick();
    return m_run && (m_pos == 0);
  endfunction

  task automatic step(input bit r, input bit e, input bit ld, input int din);
    bit st;
    int v;
    rst_       = r;
    bus.en     = e;
    bus.div_ld = ld;
    bus.div_in = CNT_W'(din);
    @(posedge clk);
    if (!r) begin
      m_run  = 0;
      m_pos  = 0;
      m_n    = 8;
      m_pend = 8;
      m_busy = 0;
      m_tcnt = 0;
    end else begin
      st = e && (!m_run || (m_pos == m_n - 1));
      if ((st || !m_run) && m_busy) begin
        m_n    = m_pend;
        m_busy = 0;
      end
      if (ld) begin
        v      = din & 255;
        m_pend = (v < 2) ? 2 : v;
        m_busy = 1;
      end
      if (!e) begin
        m_run = 0;
        m_pos = 0;
      end else if (st) begin
        m_run = 1;
        m_pos = 0;
      end else begin
        m_pos = m_pos + 1;
      end
      if (e_tick()) m_tcnt = (m_tcnt + 1) & 16'hffff;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, (i == 1), 5);
      total++;
      if ({bus.clk_out, bus.tick, bus.div_busy} !== 3'b000) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d got clk_out/tick/busy=%b required 000", i,
                 {bus.clk_out, bus.tick, bus.div_busy});
      end
    end
`ifdef CLKDIV_TICK_CNT_EN
    total++;
    if (bus.tick_cnt !== 16'h0) begin
      bad++;
      $display("FAIL reset_tick_cnt got %0h required 0", bus.tick_cnt);
    end
`endif
  endtask

  task automatic test_div8();
    int ticks[$];
    step(0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      step(1, 1, 0, 0);
      if (bus.tick === 1'b1) ticks.push_back(i);
      total++;
      if ({bus.clk_out, bus.tick, bus.div_busy} !== {e_clk(), e_tick(), m_busy}) begin
        bad++;
        $display("FAIL div8_wave cyc=%0d got clk_out/tick/busy=%b required %b", i,
                 {bus.clk_out, bus.tick, bus.div_busy}, {e_clk(), e_tick(), m_busy});
      end
      if (i == 3 || i == 4) begin
        total++;
        if (bus.clk_out !== (i == 3)) begin
          bad++;
          $display("FAIL div8_duty cyc=%0d got clk_out=%b required %b", i, bus.clk_out, (i == 3));
        end
      end
    end
    total++;
    if (ticks.size() != 4 || ticks[0] != 0) begin
      bad++;
      $display("FAIL div8_first_tick got count=%0d required 4 starting at cycle 0", ticks.size());
    end
    for (int k = 1; k < ticks.size(); k++) begin
      total++;
      if (ticks[k] - ticks[k-1] != 8) begin
        bad++;
        $display("FAIL div8_period got %0d required 8", ticks[k] - ticks[k-1]);
      end
    end
  endtask

  task automatic test_load_mid();
    int ticks[$];
    int exp_ticks[4] = '{0, 8, 13, 18};
    step(0, 0, 0, 0);
    for (int i = 0; i < 21; i++) begin
      step(1, 1, (i == 3), 5);
      if (bus.tick === 1'b1) ticks.push_back(i);
      total++;
      if ({bus.clk_out, bus.tick, bus.div_busy} !== {e_clk(), e_tick(), m_busy}) begin
        bad++;
        $display("FAIL load_mid_wave cyc=%0d got clk_out/tick/busy=%b required %b", i,
                 {bus.clk_out, bus.tick, bus.div_busy}, {e_clk(), e_tick(), m_busy});
      end
      if (i == 7 || i == 8) begin
        total++;
        if (bus.div_busy !== (i == 7)) begin
          bad++;
          $display("FAIL load_mid_busy cyc=%0d got %b required %b", i, bus.div_busy, (i == 7));
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (k >= ticks.size() || ticks[k] != exp_ticks[k]) begin
        bad++;
        $display("FAIL load_mid_tick idx=%0d got %0d required %0d", k,
                 (k < ticks.size()) ? ticks[k] : -1, exp_ticks[k]);
      end
    end
  endtask

  task automatic test_clamp();
    step(0, 0, 0, 0);
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        step(1, 0, 1, 7);
        step(1, 0, 0, 0);
      end
      step(1, 0, 1, pass);
      total++;
      if (bus.div_busy !== 1'b1) begin
        bad++;
        $display("FAIL clamp_busy_set val=%0d got %b required 1", pass, bus.div_busy);
      end
      step(1, 0, 0, 0);
      total++;
      if (bus.div_busy !== 1'b0) begin
        bad++;
        $display("FAIL clamp_busy_clr val=%0d got %b required 0", pass, bus.div_busy);
      end
      for (int i = 0; i < 8; i++) begin
        step(1, 1, 0, 0);
        total++;
        if ({bus.clk_out, bus.tick} !== {(i % 2 == 0), (i % 2 == 0)}) begin
          bad++;
          $display("FAIL clamp_toggle val=%0d cyc=%0d got clk_out/tick=%b%b required %b%b", pass,
                   i, bus.clk_out, bus.tick, (i % 2 == 0), (i % 2 == 0));
        end
      end
      step(1, 0, 0, 0);
    end
  endtask

  task automatic test_double_load();
    int ticks[$];
    int exp_ticks[4] = '{0, 8, 11, 14};
    step(0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      step(1, 1, (i == 2 || i == 5), (i == 2) ? 6 : 3);
      if (bus.tick === 1'b1) ticks.push_back(i);
      total++;
      if ({bus.clk_out, bus.tick, bus.div_busy} !== {e_clk(), e_tick(), m_busy}) begin
        bad++;
        $display("FAIL dbl_load_wave cyc=%0d got clk_out/tick/busy=%b required %b", i,
                 {bus.clk_out, bus.tick, bus.div_busy}, {e_clk(), e_tick(), m_busy});
      end
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (k >= ticks.size() || ticks[k] != exp_ticks[k]) begin
        bad++;
        $display("FAIL dbl_load_tick idx=%0d got %0d required %0d", k,
                 (k < ticks.size()) ? ticks[k] : -1, exp_ticks[k]);
      end
    end
    for (int k = 1; k < ticks.size(); k++) begin
      total++;
      if (ticks[k] - ticks[k-1] == 6) begin
        bad++;
        $display("FAIL dbl_load_no6 got period %0d required not 6", ticks[k] - ticks[k-1]);
      end
    end
  endtask

  task automatic test_stop();
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    total++;
    if ({bus.clk_out, bus.tick} !== 2'b00) begin
      bad++;
      $display("FAIL stop_high got clk_out/tick=%b%b required 00", bus.clk_out, bus.tick);
    end
    step(1, 1, 1, 4);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) step(1, 1, 0, 0);
      total++;
      if ({bus.clk_out, bus.tick, bus.div_busy} !== {e_clk(), e_tick(), m_busy}) begin
        bad++;
        $display("FAIL stop_restart cyc=%0d got clk_out/tick/busy=%b required %b", i,
                 {bus.clk_out, bus.tick, bus.div_busy}, {e_clk(), e_tick(), m_busy});
      end
    end
    step(0, 1, 0, 0);
    total++;
    if ({bus.clk_out, bus.tick, bus.div_busy} !== 3'b000) begin
      bad++;
      $display("FAIL stop_reset got clk_out/tick/busy=%b required 000",
               {bus.clk_out, bus.tick, bus.div_busy});
    end
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 0, 0);
      total++;
      if (bus.clk_out !== ((i % 8) < 4)) begin
        bad++;
        $display("FAIL stop_reset_n8 cyc=%0d got clk_out=%b required %b", i, bus.clk_out,
                 ((i % 8) < 4));
      end
    end
  endtask

  task automatic test_random();
    bit r, e, ld;
    int din;
    step(0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 199) != 0);
      e   = ($urandom_range(0, 19) != 0);
      ld  = ($urandom_range(0, 9) == 0);
      din = $urandom_range(0, 13);
      step(r, e, ld, din);
      total++;
      if ({bus.clk_out, bus.tick, bus.div_busy} !== {e_clk(), e_tick(), m_busy}) begin
        bad++;
        $display("FAIL random_wave cyc=%0d got clk_out/tick/busy=%b required %b", i,
                 {bus.clk_out, bus.tick, bus.div_busy}, {e_clk(), e_tick(), m_busy});
      end
`ifdef CLKDIV_TICK_CNT_EN
      total++;
      if (bus.tick_cnt !== 16'(m_tcnt)) begin
        bad++;
        $display("FAIL random_tick_cnt cyc=%0d got %0d required %0d", i, bus.tick_cnt, m_tcnt);
      end
`endif
    end
  endtask

`ifdef CLKDIV_TICK_CNT_EN
  task automatic test_tick_cnt_wrap();
    int wraps = 0;
    logic [15:0] prev;
    step(0, 0, 0, 0);
    step(1, 0, 1, 2);
    step(1, 0, 0, 0);
    prev = bus.tick_cnt;
    for (int i = 0; i < 131072; i++) begin
      step(1, 1, 0, 0);
      if (bus.tick_cnt == 16'h0 && prev == 16'hffff) wraps++;
      prev = bus.tick_cnt;
    end
    total++;
    if (bus.tick_cnt !== 16'h0) begin
      bad++;
      $display("FAIL tick_cnt_final got %0h required 0", bus.tick_cnt);
    end
    total++;
    if (wraps != 1) begin
      bad++;
      $display("FAIL tick_cnt_wraps got %0d required 1", wraps);
    end
  endtask
`endif

  initial begin
    bus.en     = 1'b0;
    bus.div_ld = 1'b0;
    bus.div_in = '0;
    test_reset();
    test_div8();
    test_load_mid();
    test_clamp();
    test_double_load();
    test_stop();
    test_random();
`ifdef CLKDIV_TICK_CNT_EN
    test_tick_cnt_wrap();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
